// File: rtl/pwm_pkg.sv
// Shared PWM definitions. The PWM generators use the same package, so duty
// values mean the same thing on both sides: a high time in clk cycles.
package pwm_pkg;

    localparam int CLK_HZ         = 50_000_000;
    localparam int CYC_PER_MS     = 50_000;
    localparam int PWM_PERIOD_CYC = 1_000_000;
    localparam int DUTY_W         = 20;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } cap_state_e;

    // Clamp a cycle count to the duty field width.
    function automatic logic [DUTY_W-1:0] sat20(input logic [31:0] v);
        logic [31:0] duty_max;
        duty_max = (32'd1 << DUTY_W) - 32'd1;
        if (v > duty_max) return '1;
        else              return v[DUTY_W-1:0];
    endfunction

endpackage

// File: rtl/pwm_in_filter.sv
// Input conditioning for pwm_capture: 2-flop synchronizer, optional deglitch
// filter (PWM_CAPTURE_DEGLITCH_EN), then edge detection on the clean level s.
module pwm_in_filter #(
    parameter int DEGLITCH_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pwm_in,
    output logic s,
    output logic rise,
    output logic fall
);

`ifdef PWM_CAPTURE_DEGLITCH_EN
    localparam bit FILT_ON = 1'b1;
`else
    localparam bit FILT_ON = 1'b0;
`endif

    logic [1:0] sync_q;
    logic       s_d;

    // Two-flop synchronizer for the asynchronous board input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[0], pwm_in};
    end

    if (FILT_ON && DEGLITCH_LEN > 0) begin : g_dg
        localparam int CW = $clog2(DEGLITCH_LEN + 1);
        logic          lvl;
        logic [CW-1:0] dg_cnt;

        // Flip the level only after DEGLITCH_LEN consecutive differing samples.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                lvl    <= 1'b0;
                dg_cnt <= '0;
            end else if (sync_q[1] != lvl) begin
                if (dg_cnt == CW'(DEGLITCH_LEN - 1)) begin
                    lvl    <= sync_q[1];
                    dg_cnt <= '0;
                end else begin
                    dg_cnt <= dg_cnt + CW'(1);
                end
            end else begin
                dg_cnt <= '0;
            end
        end
        assign s = lvl;
    end else begin : g_raw
        assign s = sync_q[1];
    end

    // One-cycle history of the clean level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) s_d <= 1'b0;
        else        s_d <= s;
    end

    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures high time and rising-to-rising period of pwm_in in
// clk cycles and publishes both once per period with a one-cycle strobe.
// Loss of signal (no completed period within TIMEOUT) sets sticky signal_lost.
// Optional macro PWM_CAPTURE_DEGLITCH_EN enables the input deglitch filter.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W        = 21,
    parameter int TIMEOUT      = 1_250_000,
    parameter int DEGLITCH_LEN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pwm_in,
    output logic [DUTY_W-1:0] duty,
    output logic [CNT_W-1:0]  period,
    output logic              duty_valid,
    output logic              signal_lost
);

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    cap_state_e       state, state_nxt;
    logic [CNT_W-1:0] hi_cnt, per_cnt, hi_len;
    logic             s, rise, fall;
    logic             start, publish, tmo, latch_hi;

    pwm_in_filter #(.DEGLITCH_LEN(DEGLITCH_LEN)) u_filt (
        .clk    (clk),
        .rst_n  (rst_n),
        .pwm_in (pwm_in),
        .s      (s),
        .rise   (rise),
        .fall   (fall)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SYNC;
        else        state <= state_nxt;
    end

    // Next state and datapath controls; an edge on the timeout cycle wins.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        publish   = 1'b0;
        tmo       = 1'b0;
        latch_hi  = 1'b0;
        case (state)
            SYNC: begin
                if (rise) begin
                    start     = 1'b1;
                    state_nxt = HIGH;
                end
            end
            HIGH: begin
                if (per_cnt == TMO) begin
                    tmo       = 1'b1;
                    state_nxt = SYNC;
                end else if (fall) begin
                    latch_hi  = 1'b1;
                    state_nxt = LOW;
                end
            end
            LOW: begin
                if (rise) begin
                    publish   = 1'b1;
                    start     = 1'b1;
                    state_nxt = HIGH;
                end else if (per_cnt == TMO) begin
                    tmo       = 1'b1;
                    state_nxt = SYNC;
                end
            end
            default: state_nxt = SYNC;
        endcase
    end

    // Counters, latched high time and published outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_cnt      <= '0;
            per_cnt     <= '0;
            hi_len      <= '0;
            duty        <= '0;
            period      <= '0;
            duty_valid  <= 1'b0;
            signal_lost <= 1'b1;
        end else begin
            duty_valid <= publish;
            if (publish) begin
                duty        <= sat20(32'(hi_len));
                period      <= per_cnt;
                signal_lost <= 1'b0;
            end
            if (tmo) signal_lost <= 1'b1;
            if (latch_hi) hi_len <= hi_cnt;
            if (start) begin
                hi_cnt  <= CNT_W'(1);
                per_cnt <= CNT_W'(1);
            end else if (state == HIGH || state == LOW) begin
                if (per_cnt != TMO) per_cnt <= per_cnt + CNT_W'(1);
                if (state == HIGH && s) hi_cnt <= hi_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture. u_a runs with a short timeout (200) for the
// timeout, boundary and glitch cases; u_b uses default parameters.
module tb_pwm_capture;
    import pwm_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              pwm_a, pwm_b;
    logic [DUTY_W-1:0] duty_a, duty_b;
    logic [20:0]       period_a, period_b;
    logic              valid_a, valid_b, lost_a, lost_b;

    int checks = 0;
    int fails  = 0;
    int strb_a = 0, strb_b = 0, dbl_a = 0, dbl_b = 0;
    logic prev_a = 1'b0, prev_b = 1'b0;
    int n0;

    always #10 clk = ~clk;

    pwm_capture #(.TIMEOUT(200)) u_a (
        .clk(clk), .rst_n(rst_n), .pwm_in(pwm_a), .duty(duty_a),
        .period(period_a), .duty_valid(valid_a), .signal_lost(lost_a)
    );

    pwm_capture u_b (
        .clk(clk), .rst_n(rst_n), .pwm_in(pwm_b), .duty(duty_b),
        .period(period_b), .duty_valid(valid_b), .signal_lost(lost_b)
    );

    // Strobe counting and back-to-back strobe detection.
    always @(negedge clk) begin
        if (valid_a) strb_a <= strb_a + 1;
        if (valid_b) strb_b <= strb_b + 1;
        if (valid_a && prev_a) dbl_a <= dbl_a + 1;
        if (valid_b && prev_b) dbl_b <= dbl_b + 1;
        prev_a <= valid_a;
        prev_b <= valid_b;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // n periods of hi cycles high out of per, one sample per clk cycle.
    task automatic pulses(input bit sel_b, input int hi, input int per, input int n);
        for (int k = 0; k < n; k++)
            for (int i = 0; i < per; i++) begin
                if (sel_b) pwm_b = (i < hi);
                else       pwm_a = (i < hi);
                @(negedge clk);
            end
    endtask

    initial begin
        #(60_000 * 20);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        pwm_a = 1'b0;
        pwm_b = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_duty",   32'(duty_a),   32'd0);
        chk("rst_period", 32'(period_a), 32'd0);
        chk("rst_valid",  32'(valid_a),  32'd0);
        chk("rst_lost_a", 32'(lost_a),   32'd1);
        chk("rst_lost_b", 32'(lost_b),   32'd1);
        chk("rst_state",  32'(u_a.state), 32'(SYNC));
        rst_n = 1'b1;

        chk("sat20_big",  32'(sat20(32'd1_100_000)), 32'hFFFFF);
        chk("sat20_edge", 32'(sat20(32'd1_048_576)), 32'hFFFFF);
        chk("sat20_max",  32'(sat20(32'd1_048_575)), 32'hFFFFF);
        chk("sat20_pass", 32'(sat20(32'd75_000)),    32'd75_000);

        // Default parameters: first period is never published.
        pulses(1'b1, 7500, 10000, 1);
        chk("t1_no_strb", 32'(strb_b), 32'd0);
        chk("t1_lost1",   32'(lost_b), 32'd1);
        pulses(1'b1, 7500, 10000, 2);
        repeat (10) @(negedge clk);
        chk("t1_strb",   32'(strb_b),   32'd2);
        chk("t1_duty",   32'(duty_b),   32'd7500);
        chk("t1_period", 32'(period_b), 32'd10000);
        chk("t1_lost0",  32'(lost_b),   32'd0);

        // Short pulses, then loss of signal and recovery.
        pulses(1'b0, 5, 20, 4);
        chk("t2_strb",   32'(strb_a),   32'd3);
        chk("t2_duty",   32'(duty_a),   32'd5);
        chk("t2_period", 32'(period_a), 32'd20);
        chk("t2_lost0",  32'(lost_a),   32'd0);
        repeat (150) @(negedge clk);
        chk("t2_not_yet", 32'(lost_a), 32'd0);
        repeat (60) @(negedge clk);
        chk("t2_lost1",      32'(lost_a),   32'd1);
        chk("t2_duty_hold",  32'(duty_a),   32'd5);
        chk("t2_per_hold",   32'(period_a), 32'd20);
        n0 = strb_a;
        pulses(1'b0, 5, 20, 1);
        chk("t2_resume1", 32'(strb_a), 32'(n0));
        pulses(1'b0, 5, 20, 1);
        chk("t2_resume2", 32'(strb_a), 32'(n0 + 1));
        chk("t2_relock",  32'(lost_a), 32'd0);

        // Input stuck high.
        pulses(1'b0, 5, 20, 2);
        pwm_a = 1'b1;
        repeat (10) @(negedge clk);
        n0 = strb_a;
        repeat (240) @(negedge clk);
        chk("t3_no_strb", 32'(strb_a),    32'(n0));
        chk("t3_lost",    32'(lost_a),    32'd1);
        chk("t3_state",   32'(u_a.state), 32'(SYNC));
        chk("t3_duty",    32'(duty_a),    32'd5);
        pwm_a = 1'b0;
        repeat (10) @(negedge clk);

        // Period equal to TIMEOUT: the rise wins over the timeout.
        n0 = strb_a;
        pulses(1'b0, 20, 200, 3);
        chk("t4_strb",   32'(strb_a),   32'(n0 + 2));
        chk("t4_period", 32'(period_a), 32'd200);
        chk("t4_duty",   32'(duty_a),   32'd20);
        chk("t4_lost0",  32'(lost_a),   32'd0);
        repeat (30) @(negedge clk);
        chk("t4_lost1",  32'(lost_a),   32'd1);

        // 2-cycle glitch inside a 50-cycle high phase, period 200.
        n0 = strb_a;
        for (int i = 0; i < 200; i++) begin
            pwm_a = (i < 50) && !(i == 20 || i == 21);
            @(negedge clk);
        end
        pwm_a = 1'b1;
        repeat (10) @(negedge clk);
        pwm_a = 1'b0;
        repeat (10) @(negedge clk);
`ifdef PWM_CAPTURE_DEGLITCH_EN
        chk("t6_strb",   32'(strb_a),   32'(n0 + 1));
        chk("t6_duty",   32'(duty_a),   32'd50);
        chk("t6_period", 32'(period_a), 32'd200);
`else
        chk("t6_strb",   32'(strb_a),   32'(n0 + 2));
        chk("t6_duty",   32'(duty_a),   32'd28);
        chk("t6_period", 32'(period_a), 32'd178);
`endif

        chk("dbl_valid_a", 32'(dbl_a), 32'd0);
        chk("dbl_valid_b", 32'(dbl_b), 32'd0);

        // Reset in the middle of a measurement.
        pwm_b = 1'b1;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_duty",   32'(duty_b),   32'd0);
        chk("mid_rst_period", 32'(period_b), 32'd0);
        chk("mid_rst_valid",  32'(valid_b),  32'd0);
        chk("mid_rst_lost",   32'(lost_b),   32'd1);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
Measures an incoming servo/RC-style PWM signal on a 50 MHz clock. It reports high time in clk cycles (50_000 = 1 ms), in the same encoding the team's PWM generators take as their duty input, and reports the full period. The block sits at board-level inputs, such as an RC receiver or a loop-back from the servo drivers. Measurements are published once per PWM period with a single-cycle valid strobe, and loss of signal is flagged by a timeout.

Parameters:
CNT_W, 21, width of the internal high/period counters; must satisfy 2^CNT_W > TIMEOUT
TIMEOUT, 1_250_000, cycles (25 ms) without a completed period before signal_lost is set
DEGLITCH_LEN, 4, consecutive equal samples required by the optional filter

Ports:
clk  in  1  50 MHz clock
rst_n  in  1  asynchronous, active-low reset
pwm_in  in  1  asynchronous PWM input
duty  out  20  last measured high time in clk cycles, saturated at 20'hFFFFF
period  out  CNT_W  last measured rising-to-rising time in clk cycles
duty_valid  out  1  one-cycle strobe: duty/period just updated
signal_lost  out  1  no valid period seen within TIMEOUT; sticky until the next valid measurement

Behaviour:
- Reset values: duty=0, period=0, duty_valid=0, signal_lost=1, state=SYNC, all counters 0, synchronizer flops 0.
- Input conditioning: 2-flop synchronizer produces s. Register s_d = s delayed one cycle.
  - rise = s & ~s_d
  - fall = ~s & s_d
- State machine has three states: SYNC, HIGH, LOW.
- SYNC: discards any partial pulse after reset or timeout.
  - On rise: hi_cnt<=1, per_cnt<=1, go to HIGH.
- HIGH:
  - Each cycle: per_cnt++, and hi_cnt++ while s=1.
  - On fall: latch hi_len<=hi_cnt, go to LOW.
- LOW:
  - Each cycle: per_cnt++.
  - On rise: publish, then reload hi_cnt<=1, per_cnt<=1, go to HIGH.
  - Publish means: duty<=sat20(hi_len), period<=per_cnt, duty_valid<=1 for the next cycle only, signal_lost<=0.
- Result: a clean input high for N cycles with period P yields duty=N, period=P.
  - Outputs update at the clock edge after the cycle where rise is seen.
  - From the pwm_in edge, latency is 3 cycles, plus DEGLITCH_LEN with the filter.
- Timeout: in HIGH or LOW, if per_cnt reaches TIMEOUT with no rise in that cycle: signal_lost<=1, go to SYNC, and duty/period hold their last values.
  - Covers 0 % and 100 % inputs: both are reported as lost, not as duty 0 or full.
- Simultaneous events: a rise in the same cycle that per_cnt==TIMEOUT is processed as a normal publish; the edge wins.
- Width rules:
  - per_cnt saturates at TIMEOUT; it cannot wrap.
  - sat20: hi_len > 1_048_575 gives 20'hFFFFF.
- The first period after reset or timeout is never published. At least two rising edges are required.
- duty_valid is never high on two consecutive cycles.
- Reset mid-operation: immediate return to reset values; any partial measurement is discarded.

Optional Feature:
PWM_CAPTURE_DEGLITCH_EN
- Defined: after the synchronizer, a filter updates its level only after DEGLITCH_LEN consecutive samples differ from the current level. The filter resets to 0.
  - Pulses or gaps shorter than DEGLITCH_LEN cycles are ignored.
  - Clean inputs measure identically; latency to both edges grows by DEGLITCH_LEN.
- Undefined: s is taken directly from the synchronizer, and every edge is counted.

Decomposition:
- Shared package pwm_pkg:
  - CLK_HZ=50_000_000
  - CYC_PER_MS=50_000
  - PWM_PERIOD_CYC=1_000_000
  - DUTY_W=20
  - state encoding (SYNC, HIGH, LOW)
- The package is shared with the existing PWM generators so duty encodings stay consistent.
- One natural sub-module: pwm_in_filter, containing the synchronizer, the optional deglitch, and the edge-detect outputs rise/fall.

Test Plan:
1. Reset, then pwm_in high 75_000 / period 1_000_000 for 3 periods -> no strobe on the first rise; strobe at the 2nd and 3rd rise, each with duty=75_000, period=1_000_000, signal_lost 1->0.
2. With TIMEOUT=200, input high 5 / period 20, then held low -> duty=5, period=20 strobes; 200 cycles after the last rise signal_lost=1 with duty=5 held; resuming the input needs two rises before the next strobe.
3. pwm_in stuck high after a valid period (TIMEOUT=200) -> no strobe, signal_lost=1 after 200 cycles, state SYNC.
4. With TIMEOUT=200, period exactly 200 so the rise lands on the per_cnt==TIMEOUT cycle -> publish with period=200, signal_lost stays 0.
5. High time 1_100_000 with default TIMEOUT (period 1_200_000) -> duty=20'hFFFFF, period=1_200_000.
6. With PWM_CAPTURE_DEGLITCH_EN and DEGLITCH_LEN=4, a 2-cycle glitch inside the high phase (high 50, period 200) -> duty=50, period=200. Without the macro -> the glitch splits the pulse, and duty reports the post-glitch segment.
